push_conditioner: RTL and testbench

- Transmitter side of the active-low push-button interface used by the counter/FND blocks.
- Synchronises and debounces two raw, bouncy, active-low board buttons.
- Emits clean one-cycle active-low press pulses on o_Push, with optional auto-repeat while a button is held.
- Sits between the board pins and any consumer that detects a high-to-low edge on its push inputs.

---
 rtl/push_conditioner_if.sv | 27 ++
 rtl/push_conditioner.sv | 136 +++++++++++++
 tb/tb_push_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/push_conditioner_if.sv
// push_conditioner_if
//   Bundles the button-side signals of push_conditioner.
//   i_Btn   [1:0] raw active-low buttons (0 = pressed), asynchronous to the clock
//   i_RepEn       1 = auto-repeat enabled
//   o_Push  [1:0] active-low one-cycle press events, idle 1
//   o_Held  [1:0] 1 while the button is debounced-pressed
//   master: drives the buttons (board / bench); slave: the conditioner itself.
interface push_conditioner_if;
    logic [1:0] i_Btn;
    logic       i_RepEn;
    logic [1:0] o_Push;
    logic [1:0] o_Held;

    modport master (
        output i_Btn,
        output i_RepEn,
        input  o_Push,
        input  o_Held
    );

    modport slave (
        input  i_Btn,
        input  i_RepEn,
        output o_Push,
        output o_Held
    );
endinterface

// File: rtl/push_conditioner.sv
// push_conditioner
//   Synchronises and debounces two raw active-low push buttons and emits clean
//   one-cycle active-low press pulses, with optional auto-repeat while held.
//   Ports:
//     i_Clk    system clock, all state on the rising edge
//     i_Rst_n  asynchronous active-low reset
//     bus      push_conditioner_if.slave (i_Btn, i_RepEn in; o_Push, o_Held out)
//   Each bit has a 2-flop synchroniser, a five-state FSM and one shared counter
//   (debounce / repeat delay / repeat period), cleared on every state change.
module push_conditioner #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned REP_DELAY  = 64,
    parameter int unsigned REP_PERIOD = 16
) (
    input logic               i_Clk,
    input logic               i_Rst_n,
    push_conditioner_if.slave bus
);

    localparam int unsigned MaxDr  = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
    localparam int unsigned MaxCnt = (MaxDr > REP_PERIOD) ? MaxDr : REP_PERIOD;
    localparam int unsigned CntW   = $clog2(MaxCnt);

    localparam logic [CntW-1:0] DebLast   = CntW'(DEB_CYCLES - 1);
    localparam logic [CntW-1:0] DelayLast = CntW'(REP_DELAY - 1);
    localparam logic [CntW-1:0] PerLast   = CntW'(REP_PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StHeld,
        StRepeat,
        StDbRel
    } state_e;

    for (genvar k = 0; k < 2; k++) begin : g_bit
        logic            sync1_q;
        logic            s_q;
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            emit_q, emit_d;
        logic            push_q, push_d;
        logic            held_q, held_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q + 1'b1;
            emit_d  = 1'b0;

            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (!s_q) begin
                        state_d = StDbPress;
                    end
                end
                StDbPress: begin
                    if (s_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == DebLast) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                        emit_d  = 1'b1;
                    end
                end
                StHeld: begin
                    if (s_q) begin
                        state_d = StDbRel;
                        cnt_d   = '0;
                    end else if (!bus.i_RepEn) begin
                        cnt_d = '0;
                    end else if (cnt_q == DelayLast) begin
                        state_d = StRepeat;
                        cnt_d   = '0;
                        emit_d  = 1'b1;
                    end
                end
                StRepeat: begin
                    // Release wins over a repeat pulse due in the same cycle.
                    if (s_q) begin
                        state_d = StDbRel;
                        cnt_d   = '0;
                    end else if (!bus.i_RepEn) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q == PerLast) begin
                        cnt_d  = '0;
                        emit_d = 1'b1;
                    end
                end
                StDbRel: begin
                    if (!s_q) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q == DebLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase

            // Outputs trail the FSM by one register so o_Push and o_Held line up.
            push_d = ~emit_q;
            held_d = state_q inside {StHeld, StRepeat, StDbRel};
        end

        always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
                sync1_q <= 1'b1;
                s_q     <= 1'b1;
                state_q <= StIdle;
                cnt_q   <= '0;
                emit_q  <= 1'b0;
                push_q  <= 1'b1;
                held_q  <= 1'b0;
            end else begin
                sync1_q <= bus.i_Btn[k];
                s_q     <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                emit_q  <= emit_d;
                push_q  <= push_d;
                held_q  <= held_d;
            end
        end

        assign bus.o_Push[k] = push_q;
        assign bus.o_Held[k] = held_q;
    end

endmodule

// File: tb/tb_push_conditioner.sv
// tb_push_conditioner
//   Table-driven press scenarios, hand-written corner sequences and a random
//   run, all compared every cycle against a run-length reference model.
module tb_push_conditioner;

    localparam int DEB = 16;
    localparam int DLY = 64;
    localparam int PER = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    push_conditioner_if bus ();

    push_conditioner #(
        .DEB_CYCLES(DEB),
        .REP_DELAY (DLY),
        .REP_PERIOD(PER)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, $signed(act),
                     $signed(exp), $time);
        end
    endtask

    // Reference model: a press is accepted once the synchronised level has been
    // low for DEB+1 consecutive edges, a release once high for DEB+1 edges.
    // While pressed, repeat pulses fall due after DLY (then PER) qualifying edges.
    bit         m_sync1 [2];
    bit         m_s     [2];
    bit         lvl     [2];
    bit         pend    [2];
    int         zrun    [2];
    int         orun    [2];
    int         run     [2];
    int         tgt     [2];
    logic [1:0] exp_push;
    logic [1:0] exp_held;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sync1[k] = 1'b1;
            m_s[k]     = 1'b1;
            lvl[k]     = 1'b0;
            pend[k]    = 1'b0;
            zrun[k]    = 0;
            orun[k]    = 0;
            run[k]     = 0;
            tgt[k]     = DLY;
        end
        exp_push = 2'b11;
        exp_held = 2'b00;
    endfunction

    function automatic void model_edge(input logic [1:0] btn, input logic rep);
        bit s;
        for (int k = 0; k < 2; k++) begin
            exp_push[k] = ~pend[k];
            exp_held[k] = lvl[k];
            pend[k]     = 1'b0;
            s           = m_s[k];
            if (!lvl[k]) begin
                zrun[k] = s ? 0 : zrun[k] + 1;
                if (zrun[k] == DEB + 1) begin
                    lvl[k]  = 1'b1;
                    pend[k] = 1'b1;
                    zrun[k] = 0;
                    orun[k] = 0;
                    run[k]  = 0;
                    tgt[k]  = DLY;
                end
            end else if (s) begin
                orun[k]++;
                run[k] = 0;
                tgt[k] = DLY;
                if (orun[k] == DEB + 1) begin
                    lvl[k]  = 1'b0;
                    orun[k] = 0;
                    zrun[k] = 0;
                end
            end else if (orun[k] != 0) begin
                orun[k] = 0;
                run[k]  = 0;
                tgt[k]  = DLY;
            end else if (!rep) begin
                run[k] = 0;
                tgt[k] = DLY;
            end else begin
                run[k]++;
                if (run[k] == tgt[k]) begin
                    pend[k] = 1'b1;
                    run[k]  = 0;
                    tgt[k]  = PER;
                end
            end
            m_s[k]     = m_sync1[k];
            m_sync1[k] = btn[k];
        end
    endfunction

    // One clock edge, model update, then compare outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(bus.i_Btn, bus.i_RepEn);
        else model_reset();
        #1;
        check("model_push", bus.o_Push, exp_push);
        check("model_held", bus.o_Held, exp_held);
    endtask

    typedef struct {
        logic [1:0] btn;    // level driven during the hold phase
        bit         rep;
        int         hold;   // edges the press is held
        int         n0;     // expected pulses on bit 0 (hold + settle)
        int         n1;
        int         first;  // edge index of first pulse, -1 if none
    } vec_t;

    vec_t vecs[8];

    int         c0, c1, first, np, pos, f, nrep, extra, drop;
    bit         rtgt[2];
    int         rb  [2];

    initial begin
        bus.i_Btn   = 2'b11;
        bus.i_RepEn = 1'b0;
        model_reset();

        vecs[0] = '{btn: 2'b11, rep: 1'b0, hold: 200, n0: 0, n1: 0, first: -1};
        vecs[1] = '{btn: 2'b10, rep: 1'b0, hold: 100, n0: 1, n1: 0, first: DEB + 3};
        vecs[2] = '{btn: 2'b01, rep: 1'b0, hold: 100, n0: 0, n1: 1, first: DEB + 3};
        vecs[3] = '{btn: 2'b00, rep: 1'b0, hold: 40,  n0: 1, n1: 1, first: DEB + 3};
        vecs[4] = '{btn: 2'b01, rep: 1'b1, hold: 90,  n0: 0, n1: 2, first: DEB + 3};
        vecs[5] = '{btn: 2'b10, rep: 1'b1, hold: 16,  n0: 0, n1: 0, first: -1};
        vecs[6] = '{btn: 2'b10, rep: 1'b1, hold: 17,  n0: 1, n1: 0, first: DEB + 3};
        vecs[7] = '{btn: 2'b00, rep: 1'b1, hold: 100, n0: 3, n1: 3, first: DEB + 3};

        tick();
        tick();
        check("reset_push", bus.o_Push, 2'b11);
        check("reset_held", bus.o_Held, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Table-driven press scenarios.
        for (int v = 0; v < 8; v++) begin
            bus.i_Btn   = vecs[v].btn;
            bus.i_RepEn = vecs[v].rep;
            c0    = 0;
            c1    = 0;
            first = -1;
            for (int e = 0; e < vecs[v].hold + DEB + 12; e++) begin
                if (e == vecs[v].hold) bus.i_Btn = 2'b11;
                tick();
                if (!bus.o_Push[0]) c0++;
                if (!bus.o_Push[1]) c1++;
                if (first < 0 && bus.o_Push != 2'b11) first = e;
            end
            check($sformatf("vec%0d_n0", v), c0, vecs[v].n0);
            check($sformatf("vec%0d_n1", v), c1, vecs[v].n1);
            check($sformatf("vec%0d_first", v), first, vecs[v].first);
            check($sformatf("vec%0d_held_after", v), bus.o_Held, 2'b00);
        end

        // Auto-repeat on bit 0 held 150 cycles past the first pulse.
        bus.i_RepEn = 1'b1;
        bus.i_Btn   = 2'b10;
        f = -1;
        for (int e = 0; e < 40 && f < 0; e++) begin
            tick();
            if (!bus.o_Push[0]) f = e;
        end
        check("rep_first", f, DEB + 3);
        check("rep_held_on", bus.o_Held, 2'b01);
        nrep = 0;
        for (int d = 1; d <= 150; d++) begin
            tick();
            if (!bus.o_Push[0]) begin
                check("rep_pos", d, DLY + PER * nrep);
                nrep++;
            end
        end
        check("rep_count", nrep, 6);
        bus.i_Btn = 2'b11;
        extra = 0;
        drop  = -1;
        for (int j = 0; j < DEB + 8; j++) begin
            tick();
            if (!bus.o_Push[0]) extra++;
            if (drop < 0 && !bus.o_Held[0]) drop = j;
        end
        check("rep_after_release", extra, 0);
        check("held_drop", drop, DEB + 3);

        // Bouncing press on bit 1, then a bouncing release.
        bus.i_RepEn = 1'b0;
        np  = 0;
        pos = -1;
        for (int c = 0; c < 60; c++) begin
            bus.i_Btn[1] = ((c / 5) % 2) != 0;
            tick();
            if (!bus.o_Push[1]) np++;
        end
        bus.i_Btn[1] = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (!bus.o_Push[1]) begin
                np++;
                pos = e;
            end
        end
        check("bounce_pulses", np, 1);
        check("bounce_pos", pos, DEB + 3);
        check("bounce_held", bus.o_Held[1], 1'b1);
        np = 0;
        for (int c = 0; c < 10; c++) begin
            bus.i_Btn[1] = (c % 2) == 0;
            tick();
            if (!bus.o_Push[1]) np++;
        end
        bus.i_Btn[1] = 1'b1;
        for (int e = 0; e < DEB + 10; e++) begin
            tick();
            if (!bus.o_Push[1]) np++;
        end
        check("bounce_release_pulses", np, 0);
        check("bounce_release_held", bus.o_Held[1], 1'b0);

        // Reset while bit 1 is repeating with the button still held.
        bus.i_RepEn = 1'b1;
        bus.i_Btn   = 2'b01;
        for (int e = 0; e < 100; e++) tick();
        check("pre_rst_held", bus.o_Held, 2'b10);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_push", bus.o_Push, 2'b11);
        check("rst_async_held", bus.o_Held, 2'b00);
        for (int e = 0; e < 3; e++) tick();
        rst_n = 1'b1;
        np  = 0;
        pos = -1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (!bus.o_Push[1]) begin
                np++;
                if (pos < 0) pos = e;
            end
        end
        check("post_rst_pulses", np, 1);
        check("post_rst_pos", pos, DEB + 3);
        bus.i_Btn = 2'b11;
        for (int e = 0; e < DEB + 12; e++) tick();

        // Random bouncy buttons and repeat-enable toggling, one mid-run reset.
        rtgt[0] = 1'b1;
        rtgt[1] = 1'b1;
        rb[0]   = 0;
        rb[1]   = 0;
        for (int c = 0; c < 8000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (rb[k] == 0 && $urandom_range(0, 149) == 0) begin
                    rtgt[k] = ~rtgt[k];
                    rb[k]   = $urandom_range(0, 12);
                end
                if (rb[k] > 0) begin
                    rb[k]--;
                    bus.i_Btn[k] = $urandom_range(0, 1) != 0;
                end else begin
                    bus.i_Btn[k] = rtgt[k];
                end
            end
            if ($urandom_range(0, 299) == 0) bus.i_RepEn = ~bus.i_RepEn;
            if (c == 4000) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst_push", bus.o_Push, 2'b11);
                check("rand_rst_held", bus.o_Held, 2'b00);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
